// File: rtl/cpu_pkg.sv
// Shared definitions for the 10-bit CPU control sequencer: opcodes, ALU
// encodings, FSM state encoding and instruction field positions.
package cpu_pkg;

    // Instruction fields: [9:7] opcode, [6:5] rx, [4:3] ry, [2:0] imm3
    localparam int OP_MSB  = 9;
    localparam int OP_LSB  = 7;
    localparam int RX_MSB  = 6;
    localparam int RX_LSB  = 5;
    localparam int RY_MSB  = 4;
    localparam int RY_LSB  = 3;
    localparam int IMM_MSB = 2;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LDI  = 3'b001,
        OP_MOV  = 3'b010,
        OP_ADD  = 3'b011,
        OP_SUB  = 3'b100,
        OP_LD   = 3'b101,
        OP_ST   = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_PASS_IMM = 2'b00,
        ALU_PASS_RY  = 2'b01,
        ALU_ADD      = 2'b10,
        ALU_SUB      = 2'b11
    } alu_op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALTED = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    function automatic alu_op_t alu_for(input opcode_t op);
        case (op)
            OP_MOV:  return ALU_PASS_RY;
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            default: return ALU_PASS_IMM;
        endcase
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Wait-state counter for memory accesses; expired flags the cycle on which
// the count of consecutive not-ready cycles would reach WAIT_LIMIT.
module mem_watchdog #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] count;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign expired = inc && (count == CW'(WAIT_LIMIT - 1));

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: fetch over a ready-handshaked port, decode
// the IR fed back as instr_q, and issue single-cycle datapath strobes.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int NREG       = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] instr_q,
    input  logic             mem_ready,
    output logic             ir_en,
    output logic             pc_en,
    output logic [NREG-1:0]  rx_en,
    output logic [1:0]       alu_op,
    output logic             addr_sel,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             busy,
    output logic             halted,
    output logic             fault
);

    state_t     state;
    opcode_t    opcode;
    logic [1:0] rx;
    logic       wd_inc;
    logic       wd_clr;
    logic       wd_expired;
    logic       unused_bits;

    assign opcode = opcode_t'(instr_q[OP_MSB:OP_LSB]);
    assign rx     = instr_q[RX_MSB:RX_LSB];

    // instr goes straight into the datapath IR; ry/imm3 steer datapath muxes.
    assign unused_bits = ^{instr, instr_q[RY_MSB:IMM_LSB]};

    assign wd_inc = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    assign wd_clr = !wd_inc;

    mem_watchdog #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (wd_clr),
        .inc    (wd_inc),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready)       state <= S_DECODE;
                    else if (wd_expired) state <= S_FAULT;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_NOP:                         state <= S_FETCH;
                        OP_LDI, OP_MOV, OP_ADD, OP_SUB: state <= S_EXEC;
                        OP_LD, OP_ST:                   state <= S_MEM;
                        default:                        state <= S_HALTED;
                    endcase
                end
                S_EXEC:   state <= S_FETCH;
                S_MEM: begin
                    if (mem_ready)       state <= S_FETCH;
                    else if (wd_expired) state <= S_FAULT;
                end
                S_HALTED: state <= S_HALTED;
                S_FAULT:  state <= S_FAULT;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Strobes depend combinationally on mem_ready so a ready access completes
    // in the same cycle it is granted.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        rx_en    = '0;
        alu_op   = ALU_PASS_IMM;
        addr_sel = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd = 1'b1;
                ir_en  = mem_ready;
                pc_en  = mem_ready;
            end
            S_EXEC: begin
                rx_en  = NREG'(1) << rx;
                alu_op = alu_for(opcode);
            end
            S_MEM: begin
                addr_sel = 1'b1;
                mem_rd   = (opcode == OP_LD);
                mem_wr   = (opcode == OP_ST);
                if ((opcode == OP_LD) && mem_ready) rx_en = NREG'(1) << rx;
            end
            default: ;
        endcase
    end

    assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                    (state == S_EXEC)  || (state == S_MEM);
    assign halted = (state == S_HALTED);
    assign fault  = (state == S_FAULT);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed scenarios plus random
// programs checked cycle by cycle against an instruction-level timing model.
module tb_cpu_control_fsm;

    localparam int WAIT_LIMIT = 15;

    typedef struct packed {
        logic       ir_en;
        logic       pc_en;
        logic [3:0] rx_en;
        logic [1:0] alu_op;
        logic       addr_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       busy;
        logic       halted;
        logic       fault;
    } vec_t;

    // Care masks: alu_op only matters in execute cycles, addr_sel only
    // while a memory request is outstanding.
    localparam logic [13:0] C_ALL   = 14'h3FFF;
    localparam logic [13:0] C_MEMPH = 14'b11_1111_00_1_11111;
    localparam logic [13:0] C_EXEC  = 14'b11_1111_11_0_11111;
    localparam logic [13:0] C_OTHER = 14'b11_1111_00_0_11111;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [9:0] instr = '0;
    logic [9:0] instr_q;
    logic       mem_ready = 1'b0;
    logic       ir_en, pc_en, addr_sel, mem_rd, mem_wr, busy, halted, fault;
    logic [3:0] rx_en;
    logic [1:0] alu_op;
    vec_t       obs;

    int checks = 0;
    int errors = 0;
    int term   = 0;  // 0 running, 1 halted, 2 faulted

    always #5 clk = ~clk;

    cpu_control_fsm dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .instr    (instr),
        .instr_q  (instr_q),
        .mem_ready(mem_ready),
        .ir_en    (ir_en),
        .pc_en    (pc_en),
        .rx_en    (rx_en),
        .alu_op   (alu_op),
        .addr_sel (addr_sel),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .busy     (busy),
        .halted   (halted),
        .fault    (fault)
    );

    // Datapath instruction register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     instr_q <= '0;
        else if (ir_en) instr_q <= instr;
    end

    assign obs = {ir_en, pc_en, rx_en, alu_op, addr_sel, mem_rd, mem_wr, busy, halted, fault};

    function automatic vec_t mkv(input logic ir, input logic pc, input logic [3:0] rx,
                                 input logic [1:0] alu, input logic as, input logic rd,
                                 input logic wr, input logic bz, input logic hl, input logic ft);
        return {ir, pc, rx, alu, as, rd, wr, bz, hl, ft};
    endfunction

    task automatic check(input string tag, input vec_t o, input vec_t e, input logic [13:0] care);
        checks++;
        assert ((o & care) === (e & care)) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (care %h)", tag, o, e, care);
        end
    endtask

    // One clock cycle: drive just after posedge, check at negedge.
    task automatic step(input string tag, input logic rdy, input logic st,
                        input logic [9:0] ins, input vec_t e, input logic [13:0] care);
        mem_ready = rdy;
        start     = st;
        instr     = ins;
        @(negedge clk);
        check(tag, obs, e, care);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check("reset_async", obs, '0, C_ALL);
        @(posedge clk);
        #1;
        check("reset_hold", obs, '0, C_ALL);
        reset = 1'b1;
        start = 1'b0;
        term  = 0;
    endtask

    task automatic begin_run();
        step("idle_start", 1'($urandom), 1'b1, 10'($urandom), '0, C_OTHER);
    endtask

    function automatic int pick_wait();
        int r = $urandom_range(0, 39);
        if (r < 32) return r % 4;
        if (r < 38) return WAIT_LIMIT - 1;
        return WAIT_LIMIT;
    endfunction

    // Instruction-level model: fetch takes fw+1 cycles, decode 1, execute 1,
    // memory mw+1; WAIT_LIMIT consecutive not-ready cycles end in FAULT.
    task automatic run_instr(input logic [9:0] w, input int fw, input int mw);
        logic [2:0] op  = w[9:7];
        logic [3:0] rxh = 4'b0001 << w[6:5];
        bit         ld  = (op == 3'd5);
        if (fw >= WAIT_LIMIT) begin
            for (int k = 0; k < WAIT_LIMIT; k++)
                step("fetch_wait", 1'b0, 1'b0, w, mkv(0,0,0,0,0,1,0,1,0,0), C_MEMPH);
            term = 2;
            return;
        end
        for (int k = 0; k <= fw; k++) begin
            bit last = (k == fw);
            step(last ? "fetch_done" : "fetch_wait", last, 1'b0, w,
                 mkv(last, last, 0, 0, 0, 1, 0, 1, 0, 0), C_MEMPH);
        end
        step("decode", 1'($urandom), 1'($urandom), 10'($urandom), mkv(0,0,0,0,0,0,0,1,0,0), C_OTHER);
        case (op)
            3'd0: ;
            3'd1, 3'd2, 3'd3, 3'd4:
                step("exec", 1'($urandom), 1'($urandom), 10'($urandom),
                     mkv(0, 0, rxh, 2'(op - 3'd1), 0, 0, 0, 1, 0, 0), C_EXEC);
            3'd5, 3'd6: begin
                if (mw >= WAIT_LIMIT) begin
                    for (int k = 0; k < WAIT_LIMIT; k++)
                        step("mem_wait", 1'b0, 1'b0, 10'($urandom),
                             mkv(0, 0, 0, 0, 1, ld, !ld, 1, 0, 0), C_MEMPH);
                    term = 2;
                end else begin
                    for (int k = 0; k <= mw; k++) begin
                        bit last = (k == mw);
                        step(last ? "mem_done" : "mem_wait", last, 1'b0, 10'($urandom),
                             mkv(0, 0, (ld && last) ? rxh : 4'b0, 0, 1, ld, !ld, 1, 0, 0), C_MEMPH);
                    end
                end
            end
            default: term = 1;
        endcase
    endtask

    task automatic check_terminal(input int n);
        for (int k = 0; k < n; k++) begin
            if (term == 1)
                step("halted", 1'($urandom), 1'(k % 2), 10'($urandom), mkv(0,0,0,0,0,0,0,0,1,0), C_OTHER);
            else
                step("faulted", 1'($urandom), 1'(k % 2), 10'($urandom), mkv(0,0,0,0,0,0,0,0,0,1), C_OTHER);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        apply_reset();
        step("idle_after_reset", 1'b1, 1'b0, 10'h3FF, '0, C_OTHER);

        // LDI R2,#5 then NOP: next fetch starts 3 cycles after the first.
        begin_run();
        run_instr(10'b001_10_00_101, 0, 0);
        run_instr(10'b000_00_00_000, 0, 0);
        // ADD R1,R2; ST R1,[R3] with 3 wait states; LD R3,[R0] ready on 5th cycle.
        run_instr(10'b011_01_10_000, 0, 0);
        run_instr(10'b110_01_11_000, 0, 3);
        run_instr(10'b101_11_00_000, 1, 4);
        run_instr(10'b100_00_01_000, 0, 0);
        // Watchdog: ready on the limit cycle wins, then a fetch that times out.
        run_instr(10'b010_11_01_000, WAIT_LIMIT - 1, 0);
        run_instr(10'b000_00_00_000, WAIT_LIMIT, 0);
        check_terminal(4);

        // Asynchronous reset in the middle of a fetch.
        apply_reset();
        begin_run();
        step("fetch_wait", 1'b0, 1'b0, 10'h000, mkv(0,0,0,0,0,1,0,1,0,0), C_MEMPH);
        mem_ready = 1'b0;
        #2;
        check("pre_reset_fetch", obs, mkv(0,0,0,0,0,1,0,1,0,0), C_MEMPH);
        apply_reset();
        begin_run();
        step("fetch_after_restart", 1'b0, 1'b0, 10'h000, mkv(0,0,0,0,0,1,0,1,0,0), C_MEMPH);
        run_instr(10'b111_00_00_000, 0, 0);
        check_terminal(4);

        // Memory-phase timeout on a store.
        apply_reset();
        begin_run();
        run_instr(10'b110_10_01_000, 0, WAIT_LIMIT);
        check_terminal(2);

        // Random programs.
        for (int p = 0; p < 30; p++) begin
            apply_reset();
            begin_run();
            for (int i = 0; i < 25 && term == 0; i++) begin
                logic [9:0] w = 10'($urandom);
                if (w[9:7] == 3'b111 && $urandom_range(0, 3) != 0) w[9:7] = 3'b000;
                run_instr(w, pick_wait(), pick_wait());
            end
            if (term != 0) check_terminal(3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multi-cycle control sequencer for the 10-bit CPU.
- Drives the load-enable and select inputs of the datapath's 10-bit enable-load registers: IR, PC and general registers R0..R3.
- Fetches each instruction over a ready-handshaked memory port, decodes it, and issues single-cycle enable strobes.
- Includes a wait-state watchdog on memory accesses.

Parameters:
- WIDTH, 10, instruction/data width.
- NREG, 4, number of general registers; one-hot enable width.
- WAIT_LIMIT, 15, maximum cycles to wait for mem_ready before a fault.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin execution from IDLE; single-cycle pulse.
- instr  in  10  memory read data, captured into IR by ir_en.
- mem_ready  in  1  memory handshake; access completes in the cycle it is high.
- ir_en  out  1  IR load strobe.
- pc_en  out  1  PC increment strobe.
- rx_en  out  NREG  one-hot general-register load strobes.
- alu_op  out  2  00 pass-imm, 01 pass-ry, 10 add, 11 sub.
- addr_sel  out  1  memory address source: 0 = PC, 1 = R[ry].
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- busy  out  1  high in every state except IDLE, HALTED and FAULT.
- halted  out  1  HALT executed.
- fault  out  1  memory watchdog expired.

Behaviour:
- Reset: while reset=0, state=IDLE, wait counter=0 and every output is 0, independent of clk. Reset mid-instruction aborts immediately; no strobe is produced on release.
- Instruction format: [9:7] opcode, [6:5] rx, [4:3] ry, [2:0] imm3.
- Opcodes:
  - 000 NOP
  - 001 LDI: rx <- imm3, zero-extended
  - 010 MOV: rx <- ry
  - 011 ADD: rx <- rx + ry
  - 100 SUB: rx <- rx - ry
  - 101 LD: rx <- mem[ry]
  - 110 ST: mem[ry] <- rx
  - 111 HALT
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALTED, FAULT.
- IDLE: start=1 -> FETCH next cycle. Otherwise stay.
- FETCH: mem_rd=1, addr_sel=0.
  - mem_ready=1 in the same cycle: ir_en=1, pc_en=1, counter cleared, -> DECODE.
  - mem_ready=0: counter++.
- DECODE: exactly 1 cycle, no strobes. Opcode selects the next state:
  - NOP -> FETCH
  - LDI, MOV, ADD, SUB -> EXEC
  - LD, ST -> MEM
  - HALT -> HALTED
  - Decode uses the IR-registered opcode, which the datapath feeds back as instr_q. Add an input port instr_q[9:0] after instr; it is part of the interface.
- EXEC: exactly 1 cycle. rx_en[rx]=1 and alu_op per opcode -> FETCH.
- MEM: addr_sel=1; mem_rd=1 for LD, mem_wr=1 for ST. Requests are held stable until mem_ready.
  - On mem_ready=1: LD asserts rx_en[rx] in the same cycle; ST asserts no enable. Counter cleared, -> FETCH.
- Watchdog: the counter counts cycles in FETCH/MEM with mem_ready=0.
  - When the count reaches WAIT_LIMIT: -> FAULT. Requests drop the next cycle.
  - mem_ready arriving on the limit cycle wins; no fault.
- HALTED: halted=1. FAULT: fault=1. Both are terminal until reset; start is ignored.
- Strobes (ir_en, pc_en, rx_en) are at most one cycle wide per event. rx_en is never multi-hot. mem_rd and mem_wr are never high together.
- Throughput with zero wait states: NOP = 2 cycles; LDI/MOV/ADD/SUB = 3 cycles; LD/ST = 3 cycles.
- State register updates on posedge clk only. Strobe outputs are decoded from state, opcode and mem_ready, with no further register stage.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_NOP..OP_HALT)
  - alu_op encodings
  - state encoding (3-bit)
  - field-position constants for rx/ry/imm3
- Natural sub-module: mem_watchdog, a counter with clear, inc, a WAIT_LIMIT parameter and an expired output, instantiated once.

Test Plan:
- Reset: reset=0 asynchronously mid-FETCH -> all outputs 0 before the next clk edge; start after release -> mem_rd=1 one cycle later.
- LDI: instr_q=10'b001_10_00_101 with mem_ready tied high -> sequence ir_en/pc_en, then DECODE idle, then rx_en=4'b0100 with alu_op=00. Next instruction fetched 3 cycles after the first FETCH.
- ADD then ST: ADD R1,R2 (10'b011_01_10_000) -> rx_en=4'b0010, alu_op=10. ST R1,[R3] with mem_ready delayed 3 cycles -> mem_wr and addr_sel=1 held 4 cycles, no rx_en.
- LD with wait states: mem_ready high on the 5th MEM cycle -> rx_en[rx] pulses exactly on that cycle, then FETCH.
- Watchdog: mem_ready held 0 in FETCH for 15 cycles -> fault=1, busy=0, mem_rd=0. A second case with mem_ready on cycle 15 -> no fault.
- HALT: instr_q=10'b111_00_00_000 -> halted=1 after DECODE; start pulses ignored and no further strobes until reset.
